// File: rtl/crossbar_pkg.sv
// Shared constants for the single-input crossbar: default widths and the
// helper that sizes the output-select field.
package crossbar_pkg;

  localparam int DEFAULT_BIT_WIDTH         = 32;
  localparam int DEFAULT_N_OUTPUTS         = 2;
  localparam int DEFAULT_CONTROL_BIT_WIDTH = 32;

  // Width of the select/destination field; never below 1 bit so that the
  // dest register always exists.
  function automatic int sel_width(input int n_outputs);
    return (n_outputs <= 2) ? 1 : $clog2(n_outputs);
  endfunction

endpackage

// File: rtl/crossbar_one_in_buf.sv
// One-entry valid/ready pipeline register carrying a message and its
// destination. Accepts a new entry in the same cycle the old one leaves,
// so it sustains one message per cycle.
module crossbar_one_in_buf
  import crossbar_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int DEST_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] enq_msg,
  input  logic [DEST_W-1:0]    enq_dest,
  input  logic                 enq_val,
  output logic                 enq_rdy,
  input  logic                 deq_rdy,
  output logic                 full,
  output logic [BIT_WIDTH-1:0] buf_msg,
  output logic [DEST_W-1:0]    buf_dest
);

  logic deq_fire;
  logic enq_fire;

  assign deq_fire = full && deq_rdy;
  assign enq_rdy  = !full || deq_fire;
  assign enq_fire = enq_val && enq_rdy;

  // Entry register: a new entry overrides the drain so full stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      buf_msg  <= '0;
      buf_dest <= '0;
    end else if (enq_fire) begin
      full     <= 1'b1;
      buf_msg  <= enq_msg;
      buf_dest <= enq_dest;
    end else if (deq_fire) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/crossbar_one_in.sv
// Single-input crossbar: routes each accepted message to the output chosen
// by the MSBs of the stored control word, through a one-entry buffer.
module crossbar_one_in
  import crossbar_pkg::*;
#(
  parameter int BIT_WIDTH         = DEFAULT_BIT_WIDTH,
  parameter int N_OUTPUTS         = DEFAULT_N_OUTPUTS,
  parameter int CONTROL_BIT_WIDTH = DEFAULT_CONTROL_BIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BIT_WIDTH-1:0]         recv_msg,
  input  logic                         recv_val,
  output logic                         recv_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg [0:N_OUTPUTS-1],
  output logic                         send_val [0:N_OUTPUTS-1],
  input  logic                         send_rdy [0:N_OUTPUTS-1],
  input  logic [CONTROL_BIT_WIDTH-1:0] control,
  input  logic                         control_val,
  output logic                         control_rdy
);

  localparam int SEL_W = sel_width(N_OUTPUTS);
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUTPUTS);

  logic [CONTROL_BIT_WIDTH-1:0] stored_control;
  logic [SEL_W-1:0]             sel;
  logic                         sel_ok;
  logic                         enq_rdy;
  logic                         deq_rdy;
  logic                         full;
  logic [BIT_WIDTH-1:0]         buf_msg;
  logic [SEL_W-1:0]             buf_dest;

  assign control_rdy = 1'b1;
  assign sel         = stored_control[CONTROL_BIT_WIDTH-1 -: SEL_W];
  // Out-of-range selects (non-power-of-2 output count) block the input.
  assign sel_ok      = ({1'b0, sel} < N_OUT_L);
  assign recv_rdy    = enq_rdy && sel_ok;

  generate
    if (CONTROL_BIT_WIDTH > SEL_W) begin : g_low_bits
      // Only the MSBs steer routing; the rest of the word is kept but unread.
      logic unused_ctrl_bits;
      assign unused_ctrl_bits = ^stored_control[CONTROL_BIT_WIDTH-SEL_W-1:0];
    end
  endgenerate

  // Control register: loads whenever control_val is high (always ready).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored_control <= '0;
    end else if (control_val) begin
      stored_control <= control;
    end
  end

  // Ready of the output the buffered entry is latched to; others are ignored.
  always_comb begin
    deq_rdy = 1'b0;
    for (int i = 0; i < N_OUTPUTS; i++) begin
      if (buf_dest == SEL_W'(i)) deq_rdy = send_rdy[i];
    end
  end

  crossbar_one_in_buf #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEST_W    (SEL_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .enq_msg  (recv_msg),
    .enq_dest (sel),
    .enq_val  (recv_val && sel_ok),
    .enq_rdy  (enq_rdy),
    .deq_rdy  (deq_rdy),
    .full     (full),
    .buf_msg  (buf_msg),
    .buf_dest (buf_dest)
  );

  // Output fanout: only the latched destination sees valid and data.
  always_comb begin
    for (int i = 0; i < N_OUTPUTS; i++) begin
      send_val[i] = full && (buf_dest == SEL_W'(i));
      send_msg[i] = (full && (buf_dest == SEL_W'(i))) ? buf_msg : '0;
    end
  end

endmodule

// File: tb/tb_crossbar_one_in.sv
// Bench for crossbar_one_in: a queue-based reference model checked every
// cycle on the 2-output instance, plus directed literal checks, and a
// 3-output instance for the out-of-range select case.
module tb_crossbar_one_in;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // 2-output instance
  logic [31:0] recv_msg = '0;
  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [31:0] send_msg [0:1];
  logic        send_val [0:1];
  logic        send_rdy [0:1] = '{1'b0, 1'b0};
  logic [31:0] control = '0;
  logic        control_val = 1'b0;
  logic        control_rdy;

  crossbar_one_in dut (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .control(control), .control_val(control_val), .control_rdy(control_rdy)
  );

  // 3-output instance
  logic [31:0] recv_msg3 = '0;
  logic        recv_val3 = 1'b0;
  logic        recv_rdy3;
  logic [31:0] send_msg3 [0:2];
  logic        send_val3 [0:2];
  logic        send_rdy3 [0:2] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] control3 = '0;
  logic        control_val3 = 1'b0;
  logic        control_rdy3;

  crossbar_one_in #(.BIT_WIDTH(32), .N_OUTPUTS(3), .CONTROL_BIT_WIDTH(32)) dut3 (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg3), .recv_val(recv_val3), .recv_rdy(recv_rdy3),
    .send_msg(send_msg3), .send_val(send_val3), .send_rdy(send_rdy3),
    .control(control3), .control_val(control_val3), .control_rdy(control_rdy3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending messages in arrival order, each with the
  // output it was routed to when accepted.
  typedef struct { logic [31:0] msg; int dest; } item_t;
  item_t       pend[$];
  logic [31:0] m_ctrl = '0;

  function automatic int m_sel();
    return int'(m_ctrl >> 31);
  endfunction

  function automatic bit m_room();
    return (pend.size() == 0) || (send_rdy[pend[0].dest] == 1'b1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      m_ctrl = '0;
    end else begin
      bit sent, acc;
      sent = (pend.size() != 0) && (send_rdy[pend[0].dest] == 1'b1);
      acc  = recv_val && m_room() && (m_sel() < 2);
      if (sent) void'(pend.pop_front());
      if (acc) pend.push_back('{msg: recv_msg, dest: m_sel()});
      if (control_val) m_ctrl = control;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("m_recv_rdy", recv_rdy, (m_room() && m_sel() < 2));
    chk("m_control_rdy", control_rdy, 1);
    for (int i = 0; i < 2; i++) begin
      bit          ev;
      logic [31:0] em;
      ev = (pend.size() != 0) && (pend[0].dest == i);
      em = ev ? pend[0].msg : 32'h0;
      chk($sformatf("m_send_val%0d", i), send_val[i], ev);
      chk($sformatf("m_send_msg%0d", i), send_msg[i], em);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [31:0] c);
    control = c; control_val = 1'b1;
    step();
    control_val = 1'b0;
  endtask

  initial begin
    // reset
    step(); step();
    chk("rst_send_val0", send_val[0], 0);
    chk("rst_send_val1", send_val[1], 0);
    chk("rst_recv_rdy", recv_rdy, 1);
    chk("rst_control_rdy", control_rdy, 1);
    reset = 1'b0;
    step();

    // select output 1, send 0xAAAA
    set_ctrl(32'h8000_0000);
    recv_msg = 32'hAAAA; recv_val = 1'b1;
    chk("r33_recv_rdy", recv_rdy, 1);
    step();
    recv_val = 1'b0;
    chk("r33_val1", send_val[1], 1);
    chk("r33_msg1", send_msg[1], 32'hAAAA);
    chk("r33_val0", send_val[0], 0);
    chk("r33_msg0", send_msg[0], 0);
    send_rdy[1] = 1'b1;
    step();
    send_rdy[1] = 1'b0;
    chk("r33_drained", send_val[1], 0);

    // back-to-back stream on output 0
    set_ctrl(32'h0);
    send_rdy[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      recv_msg = k; recv_val = 1'b1;
      chk($sformatf("r34_rdy%0d", k), recv_rdy, 1);
      step();
      chk($sformatf("r34_val%0d", k), send_val[0], 1);
      chk($sformatf("r34_msg%0d", k), send_msg[0], k);
    end
    recv_val = 1'b0;
    step();
    chk("r34_empty", send_val[0], 0);
    send_rdy[0] = 1'b0;

    // backpressure on output 1
    set_ctrl(32'h8000_0000);
    recv_msg = 32'h5; recv_val = 1'b1;
    step();
    recv_msg = 32'h6;
    chk("r35_blocked", recv_rdy, 0);
    step();
    chk("r35_still_blocked", recv_rdy, 0);
    chk("r35_hold5", send_msg[1], 32'h5);
    send_rdy[1] = 1'b1;
    #1;
    chk("r35_rdy_on_drain", recv_rdy, 1);
    step();
    recv_val = 1'b0; send_rdy[1] = 1'b0;
    chk("r35_val6", send_val[1], 1);
    chk("r35_msg6", send_msg[1], 32'h6);
    send_rdy[1] = 1'b1;
    step();
    send_rdy[1] = 1'b0;
    chk("r35_empty", send_val[1], 0);

    // control race: old sel=0 routes 0x7, new sel=1 routes 0x8
    set_ctrl(32'h0);
    control = 32'h8000_0000; control_val = 1'b1;
    recv_msg = 32'h7; recv_val = 1'b1;
    step();
    control_val = 1'b0;
    recv_msg = 32'h8;
    chk("r36_val0", send_val[0], 1);
    chk("r36_msg0", send_msg[0], 32'h7);
    chk("r36_val1_idle", send_val[1], 0);
    send_rdy[0] = 1'b1;
    step();
    recv_val = 1'b0; send_rdy[0] = 1'b0;
    chk("r36_val1", send_val[1], 1);
    chk("r36_msg1", send_msg[1], 32'h8);
    chk("r36_val0_done", send_val[0], 0);
    send_rdy[1] = 1'b1;
    step();
    send_rdy[1] = 1'b0;

    // reset mid-operation
    set_ctrl(32'h0);
    recv_msg = 32'h9; recv_val = 1'b1;
    step();
    recv_val = 1'b0;
    chk("r38_full", send_val[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("r38_async_val0", send_val[0], 0);
    chk("r38_async_msg0", send_msg[0], 0);
    chk("r38_async_rdy", recv_rdy, 1);
    step();
    reset = 1'b0;
    send_rdy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("r38_no_stale0", send_val[0], 0);
      chk("r38_no_stale1", send_val[1], 0);
    end
    send_rdy[0] = 1'b0;

    // out-of-range select on the 3-output instance
    control3 = 32'h8000_0000; control_val3 = 1'b1;
    step();
    control_val3 = 1'b0;
    recv_msg3 = 32'h11; recv_val3 = 1'b1;
    step();
    control3 = 32'hC000_0000; control_val3 = 1'b1;
    recv_msg3 = 32'h22;
    step();
    control_val3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("r37_rdy_low", recv_rdy3, 0);
      chk("r37_val2_held", send_val3[2], 1);
      chk("r37_msg2_held", send_msg3[2], 32'h11);
      step();
    end
    send_rdy3[0] = 1'b1; send_rdy3[1] = 1'b1; send_rdy3[2] = 1'b1;
    #1;
    chk("r37_rdy_low_drain", recv_rdy3, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("r37_rdy_low_after", recv_rdy3, 0);
      chk("r37_val0", send_val3[0], 0);
      chk("r37_val1", send_val3[1], 0);
      chk("r37_val2", send_val3[2], 0);
      step();
    end
    recv_val3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
